// File: rtl/proc_trace_pkg.sv
// Shared types and constants for the processor execution-trace buffer.
package proc_trace_pkg;

    localparam int unsigned TRACE_W = 71;

    // Controller state code for instruction decode; entering it marks one executed instruction.
    localparam logic [3:0] ST_DECODE = 4'd3;

    typedef struct packed {
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read-first output.
module trace_ram
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = TRACE_W,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register holds its value between reads; sync reset maps onto the BRAM output reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/proc_trace_buffer.sv
// Captures one record per executed instruction into a circular FIFO and replays it on request.
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter logic [3:0]  CAP_STATE = ST_DECODE,
    parameter bit          OVERWRITE = 1'b1,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         State,
    input  logic [6:0]         PC_Out,
    input  logic [15:0]        IR_Out,
    input  logic [15:0]        ALU_A,
    input  logic [15:0]        ALU_B,
    input  logic [15:0]        ALU_Out,
    input  logic               Freeze,
    input  logic               Rd_Req,
    output logic               Rd_Valid,
    output logic [TRACE_W-1:0] Rd_Data,
    output logic [CW-1:0]      Count,
    output logic               Full,
    output logic               Empty,
    output logic [7:0]         Dropped
);

    logic [3:0]    prev_state_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    dropped_q, dropped_d;
    logic          rd_valid_q;

    logic       cap;
    logic       pop;
    logic       we;
    logic       drop;
    trace_rec_t wr_rec;

    assign Full  = (count_q == CW'(DEPTH));
    assign Empty = (count_q == '0);

    assign cap = (State == CAP_STATE) && (prev_state_q != CAP_STATE) && !Freeze;
    assign pop = Rd_Req && !Empty;

    assign wr_rec = '{pc: PC_Out, ir: IR_Out, a: ALU_A, b: ALU_B, out: ALU_Out};

    always_comb begin
        we        = 1'b0;
        drop      = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (cap) begin
            // A same-cycle pop frees the slot, so a full buffer still accepts the write normally.
            if (!Full || pop) begin
                we = 1'b1;
            end else if (OVERWRITE) begin
                we       = 1'b1;
                drop     = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                drop = 1'b1;
            end
        end

        if (we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        // Overwrite replaces the oldest slot, so Count only moves on a plain write or a plain pop.
        if (we && !drop && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !we) begin
            count_d = count_q - CW'(1);
        end

        if (drop && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_state_q <= 4'hF;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dropped_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            prev_state_q <= State;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dropped_q    <= dropped_d;
            rd_valid_q   <= pop;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_W)
    ) u_ram (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_rec),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (Rd_Data)
    );

    assign Count    = count_q;
    assign Dropped  = dropped_q;
    assign Rd_Valid = rd_valid_q;

endmodule

// File: doc/proc_trace_buffer.md
Name: proc_trace_buffer

Overview:
- Downstream observer of the 16-bit processor top level.
- Watches the processor's debug outputs (State, PC_Out, IR_Out, ALU_A, ALU_B, ALU_Out) and captures one record per executed instruction into a circular FIFO.
- Records are read out through a request/valid handshake so a display or host-link block can inspect the execution history after the fact.

Parameters:
- DEPTH, 16, number of records held; power of two, 2..256.
- CAP_STATE, 4'd3, controller state whose entry triggers a capture.
- OVERWRITE, 1, 1 = when full, drop oldest record; 0 = when full, drop new record.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- State  in  4  processor current state.
- PC_Out  in  7  processor program counter.
- IR_Out  in  16  processor instruction register.
- ALU_A  in  16  ALU A operand.
- ALU_B  in  16  ALU B operand.
- ALU_Out  in  16  ALU result.
- Freeze  in  1  level; while high, no captures occur.
- Rd_Req  in  1  pulse; pop the oldest record.
- Rd_Valid  out  1  Rd_Data holds a popped record this cycle.
- Rd_Data  out  71  {PC[6:0], IR[15:0], A[15:0], B[15:0], Out[15:0]}, PC in the MSBs.
- Count  out  $clog2(DEPTH)+1  records currently stored.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- Dropped  out  8  saturating count of lost records.

Behaviour:
- Clk is the only clock. Reset is synchronous and active-high, and has priority over all other inputs.
- Reset values:
  - Count = 0, Empty = 1, Full = 0, Rd_Valid = 0, Rd_Data = 0, Dropped = 0.
  - Read and write pointers = 0.
  - prev_state = 4'hF, so a processor sitting in CAP_STATE at the end of reset captures on the first cycle after Reset deasserts.
- Entry detect:
  - prev_state registers State every cycle.
  - cap = (State == CAP_STATE) && (prev_state != CAP_STATE) && !Freeze.
  - Exactly one capture per entry; dwelling in CAP_STATE does not re-capture.
- Capture:
  - On the cap cycle, the input fields are written at wr_ptr on the clock edge.
  - Fields are sampled from the same cycle's inputs; no extra delay.
- Read:
  - Rd_Req with !Empty: Rd_Data <= mem[rd_ptr], Rd_Valid = 1 on the next cycle (latency 1), rd_ptr advances.
  - Rd_Req with Empty: ignored; Rd_Valid stays 0; Rd_Data holds its last value.
  - Rd_Valid is a single-cycle pulse per accepted request; back-to-back Rd_Req gives back-to-back pops.
- Pointers: wrap modulo DEPTH.
- Count updates:
  - cap only: +1.
  - accepted pop only: -1.
  - both in the same cycle: unchanged; both pointers advance.
- Full boundary (cap while Full):
  - Simultaneous accepted pop: a normal write; the slot is freed the same cycle and there is no drop.
  - Otherwise with OVERWRITE=1: write, advance wr_ptr and rd_ptr, Count stays DEPTH, Dropped+1.
  - Otherwise with OVERWRITE=0: discard the record, pointers unchanged, Dropped+1.
- Empty boundary:
  - cap and Rd_Req while Empty: the record is written, the request is rejected, Count becomes 1.
  - There is no write-through bypass.
- Dropped saturates at 8'hFF.
- Freeze:
  - Affects capture only; reads continue.
  - A CAP_STATE entry while Freeze is high is not captured, and not counted as dropped.
- Reset mid-operation: contents become unreachable (pointers cleared); mem is not cleared.
- Full and Empty are combinational from Count.

Decomposition:
- Shared package proc_trace_pkg holds:
  - trace_rec_t packed struct {pc[6:0], ir, a, b, out}.
  - TRACE_W = 71.
  - A state-code constant for the processor's decode state, used as the CAP_STATE default.
- One sub-module, trace_ram: simple dual-port, DEPTH x TRACE_W, synchronous write, registered read.
  - It is inferable as block RAM.
  - The top level holds pointers, counters, entry detect and the drop policy.

Test Plan:
- Reset, then State sequence 0,3,3,3,4,0,3 with PC_Out = 7'h05 then 7'h06 -> exactly 2 captures, Count = 2; pops return PC 05 then 06 with Rd_Valid one cycle after each Rd_Req.
- Empty buffer, Rd_Req pulse -> Rd_Valid stays 0, Count stays 0, Rd_Data unchanged.
- DEPTH = 4, OVERWRITE = 1, 6 captures with PC 1..6 -> Full = 1, Dropped = 2; pops yield PC 3,4,5,6, then Empty = 1.
- DEPTH = 4, OVERWRITE = 0, 6 captures with PC 1..6 -> pops yield PC 1,2,3,4; Dropped = 2.
- Full buffer, cap and Rd_Req in the same cycle -> popped record is the oldest, Count stays 4, Dropped unchanged.
- Freeze = 1 across 3 entries -> Count = 0, Dropped = 0. Reset asserted with Count = 3 -> next cycle Count = 0, Empty = 1, Rd_Valid = 0.
